// File: rtl/inst_loader.sv
// ============================================================================
// inst_loader
// ----------------------------------------------------------------------------
// Boot-time program loader. Receives a byte stream (4-byte little-endian
// word count N followed by N little-endian 32-bit words), writes each word
// into the instruction store, and holds the CPU core in reset until the
// whole program has arrived.
//
// Optional feature (compile-time macro INST_LOADER_CHECKSUM_EN):
//   When defined, an 8-bit modulo-256 sum of every data byte is accumulated
//   and one extra checksum byte is expected after the last word. A match
//   completes the load; a mismatch fails it. Words already written stay
//   written. When undefined, neither the CSUM state nor the accumulator
//   exist and completion goes straight to DONE.
//
// Parameters:
//   ADDR_BASE  byte address of instruction word 0 (must be 4-byte aligned)
//   MAX_WORDS  largest accepted program length in 32-bit words
//
// Ports:
//   clk        sole clock, rising edge
//   rst        synchronous, active-high reset
//   in_data    received program byte
//   in_valid   in_data valid this cycle
//   in_ready   loader accepts a byte this cycle (transfer = valid & ready)
//   mem_we     one-cycle write strobe to the instruction store
//   mem_addr   byte address of the write (store indexes by mem_addr >> 2)
//   mem_wdata  instruction word to write
//   cpu_hold   high in every state except DONE
//   done       program loaded successfully
//   err        load failed, sticky until rst
// ============================================================================
module inst_loader #(
    parameter logic [31:0] ADDR_BASE = 32'h0000_0000,
    parameter int unsigned MAX_WORDS = 32768
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    output logic        in_ready,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        cpu_hold,
    output logic        done,
    output logic        err
);

`ifdef INST_LOADER_CHECKSUM_EN
    typedef enum logic [2:0] {
        ST_LEN  = 3'd0,
        ST_DATA = 3'd1,
        ST_CSUM = 3'd2,
        ST_DONE = 3'd3,
        ST_ERR  = 3'd4
    } state_t;

    // Where the loader goes once the last word (or an empty program) is in.
    localparam state_t ST_COMPLETE = ST_CSUM;
`else
    typedef enum logic [2:0] {
        ST_LEN  = 3'd0,
        ST_DATA = 3'd1,
        ST_DONE = 3'd3,
        ST_ERR  = 3'd4
    } state_t;

    localparam state_t ST_COMPLETE = ST_DONE;
`endif

    localparam logic [31:0] MAX_WORDS_W = 32'(MAX_WORDS);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t      state_q,     state_d;
    logic [1:0]  byte_cnt_q,  byte_cnt_d;   // byte position within a word
    logic [31:0] word_idx_q,  word_idx_d;   // k: index of the word being built
    logic [31:0] word_cnt_q,  word_cnt_d;   // N: program length in words
    logic [31:0] shift_q,     shift_d;      // little-endian byte assembly
    logic        mem_we_q,    mem_we_d;
    logic [31:0] mem_addr_q,  mem_addr_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;
`ifdef INST_LOADER_CHECKSUM_EN
    logic [7:0]  csum_q,      csum_d;
`endif

    logic        accept;
    logic [31:0] assembled;

    // ------------------------------------------------------------------
    // Moore outputs. in_ready is forced low while rst is high so that no
    // byte is consumed by a stream source during the reset cycle.
    // ------------------------------------------------------------------
    always_comb begin
        in_ready = 1'b0;
        cpu_hold = 1'b1;
        done     = 1'b0;
        err      = 1'b0;

        unique case (state_q)
            ST_LEN:  in_ready = 1'b1;
            ST_DATA: in_ready = 1'b1;
`ifdef INST_LOADER_CHECKSUM_EN
            ST_CSUM: in_ready = 1'b1;
`endif
            ST_DONE: begin
                done     = 1'b1;
                cpu_hold = 1'b0;
            end
            ST_ERR:  err = 1'b1;
            default: err = 1'b1;
        endcase

        if (rst) begin
            in_ready = 1'b0;
        end
    end

    assign accept = in_valid & in_ready;

    // New byte enters at the top and older bytes shift down, so after four
    // accepted bytes the first one sits in bits 7:0.
    assign assembled = {in_data, shift_q[31:8]};

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        byte_cnt_d  = byte_cnt_q;
        word_idx_d  = word_idx_q;
        word_cnt_d  = word_cnt_q;
        shift_d     = shift_q;
        mem_we_d    = 1'b0;          // strobe is a single-cycle pulse
        mem_addr_d  = mem_addr_q;    // address/data hold between writes
        mem_wdata_d = mem_wdata_q;
`ifdef INST_LOADER_CHECKSUM_EN
        csum_d      = csum_q;
`endif

        unique case (state_q)
            ST_LEN: begin
                if (accept) begin
                    shift_d    = assembled;
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    if (byte_cnt_q == 2'd3) begin
                        word_cnt_d = assembled;
                        word_idx_d = '0;
                        if (assembled == 32'd0) begin
                            state_d = ST_COMPLETE;
                        end else if (assembled > MAX_WORDS_W) begin
                            state_d = ST_ERR;
                        end else begin
                            state_d = ST_DATA;
                        end
                    end
                end
            end

            ST_DATA: begin
                if (accept) begin
                    shift_d    = assembled;
                    byte_cnt_d = byte_cnt_q + 2'd1;   // wraps 3 -> 0
`ifdef INST_LOADER_CHECKSUM_EN
                    csum_d     = csum_q + in_data;
`endif
                    if (byte_cnt_q == 2'd3) begin
                        // The write is registered: strobe, address and data
                        // all appear together in the following cycle, and a
                        // byte accepted during that cycle only touches
                        // shift_q, never the write registers.
                        mem_we_d    = 1'b1;
                        mem_addr_d  = ADDR_BASE + {word_idx_q[29:0], 2'b00};
                        mem_wdata_d = assembled;
                        word_idx_d  = word_idx_q + 32'd1;
                        if ((word_idx_q + 32'd1) == word_cnt_q) begin
                            state_d = ST_COMPLETE;
                        end
                    end
                end
            end

`ifdef INST_LOADER_CHECKSUM_EN
            ST_CSUM: begin
                if (accept) begin
                    state_d = (in_data == csum_q) ? ST_DONE : ST_ERR;
                end
            end
`endif

            ST_DONE: begin
                state_d = ST_DONE;
            end

            ST_ERR: begin
                state_d = ST_ERR;
            end

            default: begin
                state_d = ST_ERR;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State registers. Reset abandons any load in progress: partial bytes,
    // counters and a pending write strobe are all cleared.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_LEN;
            byte_cnt_q  <= 2'd0;
            word_idx_q  <= '0;
            word_cnt_q  <= '0;
            shift_q     <= '0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= ADDR_BASE;
            mem_wdata_q <= '0;
`ifdef INST_LOADER_CHECKSUM_EN
            csum_q      <= 8'd0;
`endif
        end else begin
            state_q     <= state_d;
            byte_cnt_q  <= byte_cnt_d;
            word_idx_q  <= word_idx_d;
            word_cnt_q  <= word_cnt_d;
            shift_q     <= shift_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
`ifdef INST_LOADER_CHECKSUM_EN
            csum_q      <= csum_d;
`endif
        end
    end

    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_inst_loader.sv
// Bench for inst_loader: table of complete streams, hand-written reset and
// stall sequences, and randomized streams checked against a stream-level
// reference model.
module tb_inst_loader;

    localparam logic [31:0] TB_BASE = 32'hFFFF_FFF8;   // exercises 32-bit address wrap
    localparam int unsigned TB_MAX  = 4;

    logic        clk;
    logic        rst;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        cpu_hold;
    logic        done;
    logic        err;

    inst_loader #(
        .ADDR_BASE (TB_BASE),
        .MAX_WORDS (TB_MAX)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .cpu_hold  (cpu_hold),
        .done      (done),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    bit live   = 1'b0;

    logic [31:0] got_a[$];
    logic [31:0] got_d[$];
    logic [31:0] m_a[$];
    logic [31:0] m_d[$];
    logic        m_done;
    logic        m_err;

    typedef struct packed {
        logic [19:0][7:0] bytes;
        int               len;
        logic             exp_done;
        logic             exp_err;
        int               exp_nw;
        logic [31:0]      exp_a0;
        logic [31:0]      exp_d0;
        logic [31:0]      exp_al;
        logic [31:0]      exp_dl;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Write capture and per-cycle invariants, sampled on the falling edge.
    always @(negedge clk) begin
        if (mem_we === 1'b1) begin
            got_a.push_back(mem_addr);
            got_d.push_back(mem_wdata);
        end
        if (live && !rst) begin
            checks++;
            if ((done === 1'b1 && err === 1'b1) || (cpu_hold !== ~done)) begin
                errors++;
                $display("FAIL invariant: done=%b err=%b cpu_hold=%b", done, err, cpu_hold);
            end
        end
    end

    // Reference model: parses a whole byte stream by the format rules and
    // produces the list of expected writes and the final status.
    function automatic void model(input logic [7:0] s[$]);
        logic [31:0] n;
        logic [7:0]  sum;
        int          pos;
        m_a.delete();
        m_d.delete();
        m_done = 1'b0;
        m_err  = 1'b0;
        sum    = 8'd0;
        if (s.size() < 4) return;
        n = {s[3], s[2], s[1], s[0]};
        if (n > 32'(TB_MAX)) begin
            m_err = 1'b1;
            return;
        end
        pos = 4;
        for (int k = 0; k < int'(n); k++) begin
            if (pos + 4 > s.size()) return;
            m_a.push_back(TB_BASE + 32'(k) * 32'd4);
            m_d.push_back({s[pos+3], s[pos+2], s[pos+1], s[pos]});
            for (int j = 0; j < 4; j++) sum = sum + s[pos+j];
            pos += 4;
        end
`ifdef INST_LOADER_CHECKSUM_EN
        if (pos >= s.size()) return;
        if (s[pos] == sum) m_done = 1'b1;
        else               m_err  = 1'b1;
`else
        m_done = 1'b1;
`endif
    endfunction

    task automatic do_reset(input bit check_state);
        @(negedge clk);
        rst      = 1'b1;
        in_valid = 1'b0;
        @(negedge clk);
        if (check_state) begin
            chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
            chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
            chk("rst_done", {31'd0, done}, 32'd0);
            chk("rst_err", {31'd0, err}, 32'd0);
            chk("rst_cpu_hold", {31'd0, cpu_hold}, 32'd1);
            chk("rst_mem_addr", mem_addr, TB_BASE);
            chk("rst_mem_wdata", mem_wdata, 32'd0);
        end
        rst = 1'b0;
        got_a.delete();
        got_d.delete();
        live = 1'b1;
        #1;
        if (check_state) chk("post_rst_in_ready", {31'd0, in_ready}, 32'd1);
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        int budget;
        for (int g = 0; g < gap; g++) @(negedge clk);
        @(negedge clk);
        in_data  = b;
        in_valid = 1'b1;
        #1;
        budget = 0;
        while (in_ready !== 1'b1 && budget < 50) begin
            @(negedge clk);
            #1;
            budget++;
        end
        if (in_ready !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL byte_accept: in_ready=%b expected 1", in_ready);
        end else begin
            @(posedge clk);
        end
        #1;
        in_valid = 1'b0;
    endtask

    task automatic send_stream(input logic [7:0] s[$], input int gap_max);
        foreach (s[i]) send_byte(s[i], $urandom_range(0, gap_max));
        repeat (3) @(negedge clk);
    endtask

    task automatic check_ignored(input string nm);
        int nw;
        nw = got_a.size();
        @(negedge clk);
        in_data  = 8'hA5;
        in_valid = 1'b1;
        #1;
        chk({nm, "_ignored_ready"}, {31'd0, in_ready}, 32'd0);
        repeat (3) @(negedge clk);
        in_valid = 1'b0;
        chk({nm, "_ignored_nw"}, got_a.size(), nw);
    endtask

    function automatic vec_t mk(input logic [7:0] b[$], input logic d, input logic e,
                                input int nw, input logic [31:0] a0, input logic [31:0] d0,
                                input logic [31:0] al, input logic [31:0] dl);
        vec_t v;
        v.bytes = '0;
        foreach (b[i]) v.bytes[i] = b[i];
        v.len      = b.size();
        v.exp_done = d;
        v.exp_err  = e;
        v.exp_nw   = nw;
        v.exp_a0   = a0;
        v.exp_d0   = d0;
        v.exp_al   = al;
        v.exp_dl   = dl;
        return v;
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0]  sq[$];
        logic [7:0]  s[$];
        logic [31:0] n;
        logic [31:0] w;
        logic [7:0]  sum;
        vec_t        v;

        rst      = 1'b1;
        in_valid = 1'b0;
        in_data  = 8'h00;

        // ---------------- vector table ----------------
`ifdef INST_LOADER_CHECKSUM_EN
        sq = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        vecs.push_back(mk(sq, 1, 0, 0, 0, 0, TB_BASE, 32'h0));
        sq = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h01};
        vecs.push_back(mk(sq, 0, 1, 0, 0, 0, TB_BASE, 32'h0));
        sq = '{8'h01, 8'h00, 8'h00, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h0A};
        vecs.push_back(mk(sq, 1, 0, 1, TB_BASE, 32'h0403_0201, TB_BASE, 32'h0403_0201));
        sq = '{8'h01, 8'h00, 8'h00, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h0B};
        vecs.push_back(mk(sq, 0, 1, 1, TB_BASE, 32'h0403_0201, TB_BASE, 32'h0403_0201));
        sq = '{8'h02, 8'h00, 8'h00, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00,
               8'h6F, 8'h00, 8'h00, 8'h00, 8'h82};
        vecs.push_back(mk(sq, 1, 0, 2, TB_BASE, 32'h13, TB_BASE + 32'h4, 32'h6F));
`else
        sq = '{8'h02, 8'h00, 8'h00, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00,
               8'h6F, 8'h00, 8'h00, 8'h00};
        vecs.push_back(mk(sq, 1, 0, 2, TB_BASE, 32'h13, TB_BASE + 32'h4, 32'h6F));
        sq = '{8'h00, 8'h00, 8'h00, 8'h00};
        vecs.push_back(mk(sq, 1, 0, 0, 0, 0, TB_BASE, 32'h0));
        sq = '{8'h01, 8'h00, 8'h00, 8'h00, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
        vecs.push_back(mk(sq, 1, 0, 1, TB_BASE, 32'hEFBE_ADDE, TB_BASE, 32'hEFBE_ADDE));
        // Exactly MAX_WORDS words: addresses wrap past 0xFFFFFFFC to 0x0.
        sq = '{8'h04, 8'h00, 8'h00, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00,
               8'h02, 8'h00, 8'h00, 8'h00, 8'h03, 8'h00, 8'h00, 8'h00,
               8'h44, 8'h33, 8'h22, 8'h11};
        vecs.push_back(mk(sq, 1, 0, 4, 32'hFFFF_FFF8, 32'h1, 32'h0000_0004, 32'h1122_3344));
`endif
        sq = '{8'h01, 8'h80, 8'h00, 8'h00};
        vecs.push_back(mk(sq, 0, 1, 0, 0, 0, TB_BASE, 32'h0));
        sq = '{8'h05, 8'h00, 8'h00, 8'h00};
        vecs.push_back(mk(sq, 0, 1, 0, 0, 0, TB_BASE, 32'h0));

        // ---------------- reset state ----------------
        do_reset(1'b1);

        foreach (vecs[i]) begin
            v = vecs[i];
            do_reset(1'b0);
            s.delete();
            for (int j = 0; j < v.len; j++) s.push_back(v.bytes[j]);
            send_stream(s, 0);
            chk($sformatf("vec%0d_done", i), {31'd0, done}, {31'd0, v.exp_done});
            chk($sformatf("vec%0d_err", i), {31'd0, err}, {31'd0, v.exp_err});
            chk($sformatf("vec%0d_cpu_hold", i), {31'd0, cpu_hold}, {31'd0, ~v.exp_done});
            chk($sformatf("vec%0d_nw", i), got_a.size(), v.exp_nw);
            if (v.exp_nw > 0 && got_a.size() > 0) begin
                chk($sformatf("vec%0d_a0", i), got_a[0], v.exp_a0);
                chk($sformatf("vec%0d_d0", i), got_d[0], v.exp_d0);
            end
            chk($sformatf("vec%0d_addr_hold", i), mem_addr, v.exp_al);
            chk($sformatf("vec%0d_wdata_hold", i), mem_wdata, v.exp_dl);
            check_ignored($sformatf("vec%0d", i));
        end

        // ---------------- reset mid-load, then fresh stream ----------------
        for (int rep = 0; rep < 2; rep++) begin
            do_reset(1'b0);
            sq = '{8'h03, 8'h00, 8'h00, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
            send_stream(sq, rep * 20);
            do_reset(1'b0);
`ifdef INST_LOADER_CHECKSUM_EN
            sq = '{8'h01, 8'h00, 8'h00, 8'h00, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h38};
`else
            sq = '{8'h01, 8'h00, 8'h00, 8'h00, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
`endif
            send_stream(sq, rep * 20);
            chk($sformatf("rst_mid%0d_nw", rep), got_a.size(), 1);
            if (got_a.size() > 0) begin
                chk($sformatf("rst_mid%0d_addr", rep), got_a[0], TB_BASE);
                chk($sformatf("rst_mid%0d_data", rep), got_d[0], 32'hEFBE_ADDE);
            end
            chk($sformatf("rst_mid%0d_done", rep), {31'd0, done}, 32'd1);
        end

        // ---------------- long stall mid-word ----------------
        do_reset(1'b0);
        sq = '{8'h01, 8'h00, 8'h00, 8'h00, 8'hAA, 8'hBB};
        send_stream(sq, 0);
        repeat (30) @(negedge clk);
        chk("stall_in_ready", {31'd0, in_ready}, 32'd1);
        chk("stall_done", {31'd0, done}, 32'd0);
        chk("stall_nw", got_a.size(), 0);
        sq = '{8'hCC, 8'hDD};
        send_stream(sq, 0);
        chk("stall_resume_nw", got_a.size(), 1);
        if (got_a.size() > 0) chk("stall_resume_data", got_d[0], 32'hDDCC_BBAA);

        // ---------------- randomized streams vs model ----------------
        for (int it = 0; it < 40; it++) begin
            s.delete();
            n = 32'($urandom_range(0, TB_MAX + 2));
            if ($urandom_range(0, 5) == 0) n = $urandom | 32'h0000_0100;
            for (int j = 0; j < 4; j++) s.push_back(n[8*j +: 8]);
            sum = 8'd0;
            if (n <= 32'(TB_MAX)) begin
                for (int k = 0; k < int'(n); k++) begin
                    w = $urandom;
                    for (int j = 0; j < 4; j++) begin
                        s.push_back(w[8*j +: 8]);
                        sum = sum + w[8*j +: 8];
                    end
                end
`ifdef INST_LOADER_CHECKSUM_EN
                if ($urandom_range(0, 3) == 0) s.push_back(sum ^ 8'(1 + $urandom_range(0, 254)));
                else                            s.push_back(sum);
`endif
            end
            model(s);
            do_reset(1'b0);
            send_stream(s, 3);
            chk($sformatf("rnd%0d_nw", it), got_a.size(), m_a.size());
            for (int j = 0; j < m_a.size() && j < got_a.size(); j++) begin
                chk($sformatf("rnd%0d_a%0d", it, j), got_a[j], m_a[j]);
                chk($sformatf("rnd%0d_d%0d", it, j), got_d[j], m_d[j]);
            end
            chk($sformatf("rnd%0d_done", it), {31'd0, done}, {31'd0, m_done});
            chk($sformatf("rnd%0d_err", it), {31'd0, err}, {31'd0, m_err});
            chk($sformatf("rnd%0d_ready", it), {31'd0, in_ready}, {31'd0, ~(m_done | m_err)});
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/inst_loader.md
INST_LOADER -- requirements
Module: inst_loader

Interface
REQ-001 Parameter ADDR_BASE, default 32'h0000_0000: byte address of the first written instruction word; must be 4-byte aligned.
REQ-002 Parameter MAX_WORDS, default 32768: largest accepted program length in 32-bit words (instruction store depth).
REQ-003 clk  input  1  sole clock; all state updates on the rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 in_data  input  8  received program byte.
REQ-006 in_valid  input  1  in_data is valid this cycle.
REQ-007 in_ready  output  1  loader accepts a byte this cycle; a byte transfers only when in_valid and in_ready are both high.
REQ-008 mem_we  output  1  one-cycle write strobe to the instruction store.
REQ-009 mem_addr  output  32  byte address of the write; the store indexes by mem_addr >> 2.
REQ-010 mem_wdata  output  32  instruction word to write.
REQ-011 cpu_hold  output  1  high while loading; holds the core in reset until the program is complete.
REQ-012 done  output  1  program loaded successfully.
REQ-013 err  output  1  load failed; sticky until rst.

Function
REQ-014 The stream format shall be a 4-byte little-endian word count N, then N words of 4 bytes each, little-endian (first byte goes to bits 7:0).
REQ-015 The states shall be LEN, DATA, CSUM (only with the macro), DONE and ERR.
REQ-016 In LEN, in_ready=1 and the loader shall collect 4 bytes into N.
REQ-017 On the 4th LEN byte: N==0 -> DONE (CSUM if the macro is defined); N>MAX_WORDS -> ERR; otherwise -> DATA with word index k=0.
REQ-018 In DATA, in_ready=1. Bytes shall be assembled with a 2-bit byte counter that wraps 3->0.
REQ-019 The accepted 4th byte of word k shall cause, in the next cycle only, mem_we=1, mem_addr=ADDR_BASE+4*k (32-bit wrap) and mem_wdata=the assembled word.
REQ-020 The write latency shall be exactly 1 cycle after the final byte is accepted; accepting another byte during the write cycle shall be allowed and shall not corrupt the write.
REQ-021 After word N-1 is accepted, the loader shall go to DONE (or CSUM); the final mem_we pulse shall still be issued in the following cycle.
REQ-022 In DONE: done=1, cpu_hold=0, in_ready=0; further in_valid shall be ignored.
REQ-023 In ERR: err=1, cpu_hold=1, in_ready=0, and no further mem_we pulses shall occur.
REQ-024 cpu_hold shall be 1 in every state except DONE; done and err shall never both be 1.
REQ-025 in_valid held low for any number of cycles shall stall the loader with its state unchanged; there shall be no timeout.
REQ-026 mem_addr and mem_wdata shall hold their last values when mem_we=0.

Reset
REQ-027 When rst=1 at a clock edge, the next state shall be LEN, with byte counter=0, k=0, N=0, mem_we=0, mem_addr=ADDR_BASE, mem_wdata=0, done=0, err=0, cpu_hold=1, in_ready=0 during reset and 1 after it.
REQ-028 Reset asserted mid-load shall abandon the load, cancel any pending mem_we, and discard partial bytes; the next accepted byte is count byte 0.

Configuration
REQ-029 With macro INST_LOADER_CHECKSUM_EN defined, the loader shall accumulate an 8-bit sum (mod 256) of all data bytes.
REQ-030 With the macro defined, after the last word the loader shall enter CSUM (in_ready=1) and accept one byte: equal to the sum -> DONE; otherwise -> ERR. Words already written shall not be rolled back.
REQ-031 With the macro undefined, there shall be no CSUM state or accumulator, and completion shall go directly to DONE.

Verification
REQ-032 Bytes 02 00 00 00, 13 00 00 00, 6F 00 00 00 (macro off) -> mem_we pulses writing addr 0x0 data 0x00000013, then addr 0x4 data 0x0000006F; then done=1, cpu_hold=0.
REQ-033 Count 00 00 00 00 -> DONE with no mem_we pulse (macro on: CSUM expects 00; 00 -> done, 01 -> err).
REQ-034 Count 01 80 00 00 (32769 > MAX_WORDS) -> err=1, no mem_we, in_ready=0 thereafter.
REQ-035 Macro on, one word 01 02 03 04 followed by checksum 0A -> done=1; the same stream with checksum 0B -> err=1, yet word 0x04030201 is still written at addr 0x0.
REQ-036 rst pulsed after 2 bytes of word 1 of a 3-word load, then a fresh 1-word stream DE AD BE EF -> single write of 0xEFBEADDE to addr 0x0; in_valid gaps of 0-20 cycles between bytes give identical results.
